// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register (USR) sequencer:
// USR mode selects, command opcodes and controller states.
package usr_pkg;

  localparam logic [2:0] SEL_SISO = 3'd0;
  localparam logic [2:0] SEL_SIPO = 3'd1;
  localparam logic [2:0] SEL_PISO = 3'd2;
  localparam logic [2:0] SEL_PIPO = 3'd3;

  localparam logic [1:0] OP_SER_IN  = 2'd0;
  localparam logic [1:0] OP_SER_OUT = 2'd1;
  localparam logic [1:0] OP_LOOP    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_IN,
    ST_SHIFT_OUT,
    ST_CAPTURE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for the USR: runs serial capture, serial transmit or
// parallel loopback, and returns the resulting word on a response channel.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [N-1:0]     cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic             rsp_err,
  input  logic             ser_in,
  input  logic             ser_in_valid,
  output logic             ser_in_ready,
  output logic             ser_out,
  output logic             ser_out_valid,
  input  logic             ser_out_ready,
  output logic             busy,
  output logic [2:0]       usr_sel,
  output logic             usr_ctrl,
  output logic [N-1:0]     usr_pin,
  output logic             usr_sin,
  input  logic [N-1:0]     usr_pout,
  input  logic             usr_sout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;
  logic [N-1:0]     data_reg, data_next;
  logic [N-1:0]     rsp_data_reg, rsp_data_next;
  logic             rsp_err_reg, rsp_err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      op_reg       <= OP_SER_IN;
      data_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      data_reg     <= data_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  // All USR pins default to a parked hold so every state freezes the register
  // unless it explicitly asks for a shift or load.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_next       = op_reg;
    data_next     = data_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    ser_in_ready  = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;
    usr_sel       = SEL_SISO;
    usr_ctrl      = 1'b1;
    usr_pin       = '0;
    usr_sin       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_next   = cmd_op;
          data_next = cmd_data;
          case (cmd_op)
            OP_SER_IN:           state_next = ST_SHIFT_IN;
            OP_SER_OUT, OP_LOOP: state_next = ST_LOAD;
            default: begin
              rsp_data_next = '0;
              rsp_err_next  = 1'b1;
              state_next    = ST_RESP;
            end
          endcase
        end
      end

      ST_LOAD: begin
        usr_sel    = SEL_PIPO;
        usr_ctrl   = 1'b0;
        usr_pin    = data_reg;
        state_next = (op_reg == OP_SER_OUT) ? ST_SHIFT_OUT : ST_CAPTURE;
      end

      ST_SHIFT_IN: begin
        usr_sel      = SEL_SIPO;
        ser_in_ready = 1'b1;
        usr_sin      = ser_in;
        usr_ctrl     = ~ser_in_valid;
        if (ser_in_valid) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            state_next = ST_CAPTURE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      ST_SHIFT_OUT: begin
        usr_sel       = SEL_PISO;
        ser_out       = usr_sout;
        ser_out_valid = 1'b1;
        usr_ctrl      = ~ser_out_ready;
        if (ser_out_ready) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next      = '0;
            rsp_data_next = data_reg;
            rsp_err_next  = 1'b0;
            state_next    = ST_RESP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      // usr_pout reflects the last shift/load edge by this cycle.
      ST_CAPTURE: begin
        rsp_data_next = usr_pout;
        rsp_err_next  = 1'b0;
        state_next    = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state_reg != ST_IDLE);
  assign rsp_data = rsp_data_reg;
  assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench: usr_seq_ctrl driving a behavioural USR, with directed
// and randomized transactions checked against a word-level reference model.
module tb_usr_seq_ctrl;
  import usr_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [N-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_data;
  logic         rsp_err;
  logic         ser_in = 1'b0;
  logic         ser_in_valid = 1'b0;
  logic         ser_in_ready;
  logic         ser_out;
  logic         ser_out_valid;
  logic         ser_out_ready = 1'b0;
  logic         busy;
  logic [2:0]   usr_sel;
  logic         usr_ctrl;
  logic [N-1:0] usr_pin;
  logic         usr_sin;
  logic [N-1:0] usr_pout;
  logic         usr_sout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  usr_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ser_in(ser_in), .ser_in_valid(ser_in_valid), .ser_in_ready(ser_in_ready),
    .ser_out(ser_out), .ser_out_valid(ser_out_valid), .ser_out_ready(ser_out_ready),
    .busy(busy), .usr_sel(usr_sel), .usr_ctrl(usr_ctrl), .usr_pin(usr_pin),
    .usr_sin(usr_sin), .usr_pout(usr_pout), .usr_sout(usr_sout)
  );

  // Behavioural universal shift register
  logic [N-1:0] usr_q = '0;
  always_ff @(posedge clk) begin
    if (!usr_ctrl) begin
      case (usr_sel)
        SEL_SIPO: usr_q <= {usr_sin, usr_q[N-1:1]};
        SEL_PISO: usr_q <= {1'b0, usr_q[N-1:1]};
        SEL_PIPO: usr_q <= usr_pin;
        default:  usr_q <= usr_q;
      endcase
    end
  end
  assign usr_pout = usr_q;
  assign usr_sout = usr_q[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command end to end. bits[i] is the i-th serial input bit; a forced
  // stall of stall_len cycles is applied once the stream reaches bit stall_at.
  task automatic run_txn(input logic [1:0] op, input logic [N-1:0] data,
                         input logic [N-1:0] bits, input int pct, input int stall_at,
                         input int stall_len, input int rsp_delay, input int exp_lat);
    int cyc, in_idx, out_idx, stall_cnt, rsp_seen, lat;
    bit done, forced, rnd;
    logic [N-1:0] exp_data;
    logic exp_err;
    exp_err  = (op == OP_ILLEGAL);
    exp_data = (op == OP_SER_IN) ? bits : (op == OP_ILLEGAL) ? '0 : data;
    cyc = 0; in_idx = 0; out_idx = 0; stall_cnt = 0; rsp_seen = 0; lat = -1; done = 0;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    #1;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      // Junk commands while busy must never be accepted
      cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_data = N'($urandom);
      forced = (stall_cnt < stall_len) &&
               ((ser_in_ready && in_idx == stall_at) || (ser_out_valid && out_idx == stall_at));
      if (forced) stall_cnt++;
      rnd = ($urandom_range(99, 0) < pct);
      ser_in_valid  = (in_idx < N) && !forced && !rnd;
      ser_in        = ser_in_valid ? bits[in_idx] : 1'($urandom);
      ser_out_ready = !forced && !rnd;
      rsp_ready     = rsp_valid ? (rsp_seen >= rsp_delay) : 1'($urandom);
      #1;
      if (op != OP_SER_IN) check("ser_in_ready_scope", ser_in_ready, 0);
      if (op != OP_SER_OUT) check("ser_out_valid_scope", ser_out_valid, 0);
      if (ser_in_ready) begin
        check("in_usr_ctrl", usr_ctrl, ser_in_valid ? 0 : 1);
        if (ser_in_valid) in_idx++;
      end
      if (ser_out_valid) begin
        if (out_idx < N) check("ser_out_bit", ser_out, data[out_idx]);
        else check("ser_out_extra", out_idx, N - 1);
        check("out_usr_ctrl", usr_ctrl, ser_out_ready ? 0 : 1);
        if (ser_out_ready) out_idx++;
      end
      check("busy_in_txn", busy, 1);
      if (rsp_valid) begin
        if (lat < 0) begin
          lat = cyc;
          if (exp_lat >= 0) check("latency", lat, exp_lat);
        end
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", rsp_err, exp_err);
        check("cmd_ready_resp", cmd_ready, 0);
        if (rsp_ready) done = 1;
        rsp_seen++;
      end
    end
    if (!done) begin
      tests++; fails++;
      $error("FAIL txn_timeout: observed no response after %0d cycles, required one", cyc);
    end
    @(negedge clk);
    cmd_valid = 1'b0; ser_in_valid = 1'b0; ser_out_ready = 1'b0; rsp_ready = 1'b0;
    #1;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("post_cmd_ready", cmd_ready, 1);
    if (op == OP_SER_IN)  check("in_bit_count", in_idx, N);
    if (op == OP_SER_OUT) check("out_bit_count", out_idx, N);
    $display("[TB] txn op=%0d data=%h bits=%h exp=%h err=%0d lat=%0d rsp_wait=%0d",
             op, data, bits, exp_data, exp_err, lat, rsp_seen);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_usr_ctrl", usr_ctrl, 1);
    check("rst_usr_sel", usr_sel, SEL_SISO);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_ser_in_ready", ser_in_ready, 0);
    check("rel_ser_out_valid", ser_out_valid, 0);
    check("rel_usr_pin", usr_pin, 0);
    check("rel_usr_sin", usr_sin, 0);

    // Directed cases with derived latencies
    run_txn(OP_SER_IN,  4'b0000, 4'b1101, 0, N, 0, 0, N + 2);
    run_txn(OP_SER_OUT, 4'b1011, 4'b0000, 0, N, 0, 0, N + 2);
    run_txn(OP_SER_OUT, 4'b1011, 4'b0000, 0, 2, 3, 0, N + 2 + 3);
    run_txn(OP_SER_IN,  4'b0000, 4'b1101, 0, 1, 2, 0, N + 2 + 2);
    run_txn(OP_LOOP,    4'b1111, 4'b0000, 0, N, 0, 0, 3);
    run_txn(OP_ILLEGAL, 4'b1010, 4'b0000, 0, N, 0, 0, 1);
    run_txn(OP_LOOP,    4'b0110, 4'b0000, 0, N, 0, 5, 3);

    // Reset in the middle of a serial capture
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SER_IN;
    @(negedge clk);
    cmd_valid = 1'b0; ser_in_valid = 1'b1; ser_in = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ser_in_ready", ser_in_ready, 0);
    check("midrst_usr_ctrl", usr_ctrl, 1);
    check("midrst_usr_sel", usr_sel, SEL_SISO);
    check("midrst_usr_sin", usr_sin, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    ser_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("midrst_no_rsp", rsp_valid, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
    end

    // Randomized transactions with random stalls
    for (int t = 0; t < 24; t++) begin
      run_txn(2'($urandom_range(3, 0)), N'($urandom), N'($urandom), 25,
              $urandom_range(N - 1, 0), $urandom_range(3, 0), $urandom_range(3, 0), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Transaction sequencer for the universal shift register (USR). It accepts one command at a time over a valid/ready interface and drives the USR sel/ctrl/pin/sin pins to run one of three operations:
- serial-in capture
- serial-out transmit
- parallel loopback

Parallel results are returned over a valid/ready response channel. Serial streams have per-bit valid/ready backpressure, and the USR is frozen (hold) whenever a stream stalls.

Parameters:
N, 4, USR word width in bits
CNT_W, 3, bit counter width; must satisfy 2^CNT_W > N

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  operation code (see package)
cmd_data  in  N  word for OP_SER_OUT and OP_LOOP
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_data  out  N  captured word
rsp_err  out  1  command was illegal
ser_in  in  1  serial input bit
ser_in_valid  in  1  ser_in holds a valid bit
ser_in_ready  out  1  controller accepting serial input
ser_out  out  1  serial output bit (LSB first)
ser_out_valid  out  1  ser_out valid
ser_out_ready  in  1  downstream accepts ser_out
busy  out  1  state != IDLE
usr_sel  out  3  USR mode select
usr_ctrl  out  1  USR control: 0 = active (shift/load), 1 = hold
usr_pin  out  N  USR parallel input
usr_sin  out  1  USR serial input
usr_pout  in  N  USR parallel output
usr_sout  in  1  USR serial output (current LSB)

Behaviour:
USR contract:
- usr_ctrl=0 with SEL_SIPO shifts usr_sin into the MSB, moving bits toward the LSB, one position per clk.
- usr_ctrl=0 with SEL_PISO shifts out the LSB, which is visible on usr_sout before the edge.
- usr_ctrl=0 with SEL_PIPO loads usr_pin.
- The register updates on the edge; usr_pout is valid the following cycle.

Reset (rst=0, asynchronous):
- state=IDLE, cnt=0.
- usr_ctrl=1, usr_sel=SEL_SISO, usr_pin=0, usr_sin=0.
- rsp_valid=0, rsp_data=0, rsp_err=0, ser_out_valid=0, ser_in_ready=0, busy=0.
- cmd_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation abandons the transaction; no response is produced.

FSM states: IDLE, LOAD, SHIFT_IN, SHIFT_OUT, CAPTURE, RESP.
- IDLE: cmd_ready=1, usr_ctrl=1. On cmd_valid, latch the op and data, then:
  - OP_SER_IN -> SHIFT_IN
  - OP_SER_OUT, OP_LOOP -> LOAD
  - OP_ILLEGAL -> RESP with rsp_err=1, rsp_data=0
- LOAD (1 cycle): usr_sel=SEL_PIPO, usr_ctrl=0, usr_pin=latched data. Next state is SHIFT_OUT for OP_SER_OUT, CAPTURE for OP_LOOP.
- SHIFT_IN: usr_sel=SEL_SIPO, ser_in_ready=1, usr_sin=ser_in, usr_ctrl=~ser_in_valid.
  - Each accepted bit increments cnt.
  - On the Nth accepted bit, clear cnt and go to CAPTURE.
  - If ser_in_valid is low: hold, no count.
- SHIFT_OUT: usr_sel=SEL_PISO, ser_out=usr_sout, ser_out_valid=1, usr_ctrl=~ser_out_ready.
  - Each handshake increments cnt.
  - On the Nth handshake, go to RESP with rsp_data=latched data, rsp_err=0.
  - Stall holds ser_out stable.
- CAPTURE (1 cycle): usr_ctrl=1; latch rsp_data=usr_pout, rsp_err=0; go to RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_err stable until rsp_ready. On the rsp_valid&&rsp_ready cycle, return to IDLE; the next command can be accepted one cycle later.

Timing and edge conditions:
- cmd_ready is combinational from state only; there is no cmd→ready path.
- Latency with no stalls: SER_IN = N+2 cycles from accept to rsp_valid, SER_OUT = N+2, LOOP = 3.
- ser_in_valid outside SHIFT_IN and ser_out_ready outside SHIFT_OUT are ignored.
- cnt never exceeds N.

Decomposition:
Package usr_pkg holds:
- SEL_SISO=3'd0, SEL_SIPO=3'd1, SEL_PISO=3'd2, SEL_PIPO=3'd3
- OP_SER_IN=2'd0, OP_SER_OUT=2'd1, OP_LOOP=2'd2, OP_ILLEGAL=2'd3
- the state encoding

Single module with no sub-module. The bench instantiates usr_seq_ctrl together with USR.

Test Plan:
- Reset: rst=0 mid-SHIFT_IN → all outputs take reset values immediately; after rst=1, cmd_ready=1 and no rsp_valid appears.
- SER_IN, N=4: ser_in bits 1,0,1,1 with valid held high → rsp_data=4'b1101, rsp_err=0, rsp_valid at cycle 6 after accept.
- SER_OUT: cmd_data=4'b1011, ser_out_ready high → ser_out sequence 1,1,0,1 on 4 consecutive cycles; rsp_data=4'b1011.
- Backpressure: SER_OUT 4'b1011 with ser_out_ready low for 3 cycles after the 2nd bit → ser_out held at 0, usr_ctrl=1, exactly 4 bits transferred. Same check for SER_IN with ser_in_valid gaps.
- LOOP 4'b1111, then an illegal op → first rsp_data=4'b1111 at cycle 3; second rsp_err=1, rsp_data=0.
- Response stall: rsp_ready low for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0, new cmd_valid not accepted until one cycle after the handshake.
